nios_lcd_ctrl: RTL

//  Avalon-MM slave that drives an HD44780-style character LCD. It is the successor to the plain
//  32-bit LCD output port. Nios software pushes command/data bytes into a FIFO. A bus-timing FSM

---
 rtl/nios_lcd_ctrl_if.sv | 34 +++
 rtl/nios_lcd_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/nios_lcd_ctrl_if.sv
// ---------------------------------------------------------------------------
// nios_lcd_ctrl_if
// Avalon-MM slave bus bundle for the character-LCD controller.
//   address    [1:0]  register select
//   chipselect        slave select
//   write_n           active-low write strobe
//   writedata  [31:0] write data
//   readdata   [31:0] read data (combinational, zero wait states)
// master modport: the bus side (CPU / interconnect / testbench)
// slave  modport: the LCD controller
// ---------------------------------------------------------------------------
interface nios_lcd_ctrl_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/nios_lcd_ctrl.sv
// ---------------------------------------------------------------------------
// nios_lcd_ctrl
// Avalon-MM slave driving an HD44780-style character LCD. Software pushes
// command/data bytes into a FIFO; a timing FSM pops each entry and produces
// RS/DATA setup, the E pulse and the post-write hold on its own.
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   bus        Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   lcd_data   LCD DB[7:0]
//   lcd_rs     0 = instruction, 1 = data
//   lcd_rw     tied 0, the LCD is only ever written
//   lcd_en     LCD enable strobe
// Register map (write = chipselect & ~write_n):
//   0 DATA  W: push {1,wd[7:0]}   R: status
//   1 CMD   W: push {0,wd[7:0]}   R: status
//   2 STAT  R: [0]busy [1]full [2]empty [3]enable [15:8]level [16]overflow
//           W: wd[16]=1 clears overflow
//   3 CTRL  R/W: [0]enable; W: wd[1]=1 flushes the FIFO (reads back 0)
// ---------------------------------------------------------------------------
module nios_lcd_ctrl #(
   parameter int FIFO_DEPTH    = 16,
   parameter int SETUP_CYC     = 2,
   parameter int EN_CYC        = 25,
   parameter int HOLD_CYC      = 2000,
   parameter int LONG_HOLD_CYC = 82000
) (
   input  logic            clk,
   input  logic            reset,
   nios_lcd_ctrl_if.slave  bus,
   output logic [7:0]      lcd_data,
   output logic            lcd_rs,
   output logic            lcd_rw,
   output logic            lcd_en
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   // The single down-counter must hold the largest of the four delays.
   localparam int MAX_A = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
   localparam int MAX_B = (HOLD_CYC > LONG_HOLD_CYC) ? HOLD_CYC : LONG_HOLD_CYC;
   localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW    = $clog2(MAX_C + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_PULSE = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   logic [8:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [LW-1:0] level_reg;
   logic          overflow_reg;
   logic          enable_reg;

   state_t        state_reg;
   logic [CW-1:0] cnt_reg;
   logic [7:0]    lcd_data_reg;
   logic          lcd_rs_reg;
   logic          lcd_en_reg;

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   logic wr_en;
   logic push_req;
   logic push_rs;
   logic push_ok;
   logic flush;
   logic ovf_clear;
   logic ctrl_wr;
   logic pop;
   logic full;
   logic empty;
   logic busy;
   logic long_cmd;

   assign wr_en     = bus.chipselect & ~bus.write_n;
   assign push_req  = wr_en & ((bus.address == 2'd0) | (bus.address == 2'd1));
   assign push_rs   = (bus.address == 2'd0);
   assign ctrl_wr   = wr_en & (bus.address == 2'd3);
   assign flush     = ctrl_wr & bus.writedata[1];
   assign ovf_clear = wr_en & (bus.address == 2'd2) & bus.writedata[16];

   assign full  = (level_reg == LW'(FIFO_DEPTH));
   assign empty = (level_reg == '0);
   assign busy  = (state_reg != ST_IDLE);

   // A flush in the same cycle as a would-be pop wins: the entry is discarded,
   // not sent. A full FIFO drops the push even if a pop happens alongside.
   assign pop     = (state_reg == ST_IDLE) & enable_reg & ~empty & ~flush;
   assign push_ok = push_req & ~full & ~flush;

   // Clear/home instructions need the long post-write hold.
   assign long_cmd = ~lcd_rs_reg & ((lcd_data_reg == 8'h01) | (lcd_data_reg == 8'h02));

   // ------------------------------------------------------------------
   // FIFO storage (no reset so it maps onto block RAM)
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_mem[wr_ptr_reg] <= {push_rs, bus.writedata[7:0]};
      end
   end

   // ------------------------------------------------------------------
   // FIFO pointers, level, overflow flag, enable bit
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         overflow_reg <= 1'b0;
         enable_reg   <= 1'b1;
      end else begin
         if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
         end else begin
            // Pointers are AW bits wide and wrap naturally (depth is 2^AW).
            if (push_ok) begin
               wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
               rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop})
               2'b10:   level_reg <= level_reg + 1'b1;
               2'b01:   level_reg <= level_reg - 1'b1;
               default: level_reg <= level_reg;
            endcase
         end

         // Setting the sticky flag takes priority over a simultaneous clear.
         if (push_req & full & ~flush) begin
            overflow_reg <= 1'b1;
         end else if (ovf_clear) begin
            overflow_reg <= 1'b0;
         end

         if (ctrl_wr) begin
            enable_reg <= bus.writedata[0];
         end
      end
   end

   // ------------------------------------------------------------------
   // LCD bus-timing FSM with registered outputs. Each timed state loads the
   // counter with its length on entry and leaves when the count reaches 1,
   // so a state loaded with N lasts exactly N cycles.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         cnt_reg      <= '0;
         lcd_data_reg <= 8'h00;
         lcd_rs_reg   <= 1'b0;
         lcd_en_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               lcd_en_reg <= 1'b0;
               if (pop) begin
                  // Registered read of the FIFO head straight into the pins.
                  lcd_rs_reg   <= fifo_mem[rd_ptr_reg][8];
                  lcd_data_reg <= fifo_mem[rd_ptr_reg][7:0];
                  cnt_reg      <= CW'(SETUP_CYC);
                  state_reg    <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (cnt_reg == CW'(1)) begin
                  cnt_reg    <= CW'(EN_CYC);
                  lcd_en_reg <= 1'b1;
                  state_reg  <= ST_PULSE;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            ST_PULSE: begin
               if (cnt_reg == CW'(1)) begin
                  lcd_en_reg <= 1'b0;
                  cnt_reg    <= long_cmd ? CW'(LONG_HOLD_CYC) : CW'(HOLD_CYC);
                  state_reg  <= ST_HOLD;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            ST_HOLD: begin
               if (cnt_reg == CW'(1)) begin
                  state_reg <= ST_IDLE;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            default: begin
               state_reg  <= ST_IDLE;
               lcd_en_reg <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Read mux (combinational, zero wait states)
   // ------------------------------------------------------------------
   logic [31:0] status;

   always_comb begin
      status        = 32'h0;
      status[0]     = busy;
      status[1]     = full;
      status[2]     = empty;
      status[3]     = enable_reg;
      status[15:8]  = 8'(level_reg);
      status[16]    = overflow_reg;
   end

   always_comb begin
      bus.readdata = status;
      if (bus.address == 2'd3) begin
         bus.readdata = {31'h0, enable_reg};
      end
   end

   assign lcd_data = lcd_data_reg;
   assign lcd_rs   = lcd_rs_reg;
   assign lcd_en   = lcd_en_reg;
   assign lcd_rw   = 1'b0;

endmodule
